// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the multi-port register-file RAM.
//   state_t            - init sequencer state (INIT while filling, RUN after)
//   INIT_VALUE_DEFAULT - word value written to every location during INIT
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int INIT_VALUE_DEFAULT = 2;

endpackage

// File: rtl/ram_regfile_mp_if.sv
// ram_regfile_mp_if: port bundle for the three-port register file.
//   Port A : ce_a, we_a, addr_a, di_a -> do_a   (read/write)
//   Port B : ce_b, we_b, addr_b, di_b           (write-only)
//   Port C : ce_c, addr_c             -> do_c   (read-only)
//   Status : ready, collision, state (debug view of the init FSM)
//
// Transfer semantics (no backpressure): a port acts on a falling clock edge
// when its ce is high (and we for writes) and ready is high. Read data is
// registered at that edge and held until the next one; a read output is
// high-impedance whenever the last edge carried no read for that port.
interface ram_regfile_mp_if
  import ram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             ce_a;
  logic             we_a;
  logic [AW-1:0]    addr_a;
  logic [WIDTH-1:0] di_a;
  logic [WIDTH-1:0] do_a;

  logic             ce_b;
  logic             we_b;
  logic [AW-1:0]    addr_b;
  logic [WIDTH-1:0] di_b;

  logic             ce_c;
  logic [AW-1:0]    addr_c;
  logic [WIDTH-1:0] do_c;

  logic             ready;
  logic             collision;
  state_t           state;

  modport master (
    output ce_a, we_a, addr_a, di_a,
    output ce_b, we_b, addr_b, di_b,
    output ce_c, addr_c,
    input  do_a, do_c, ready, collision, state
  );

  modport slave (
    input  ce_a, we_a, addr_a, di_a,
    input  ce_b, we_b, addr_b, di_b,
    input  ce_c, addr_c,
    output do_a, do_c, ready, collision, state
  );

endinterface

// File: rtl/ram_init_seq.sv
// ram_init_seq: fills the array after reset.
//   clk       in  falling edge is the active edge
//   rst       in  asynchronous, active-high; restarts from word 0
//   state     out INIT while filling, RUN afterwards (also a debug view)
//   ready     out high in RUN
//   init_addr out word being written this cycle
//   init_we   out high while in INIT
// The word DEPTH-1 is written on the same edge that moves the FSM to RUN,
// so ready rises exactly on that edge.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output state_t        state,
  output logic          ready,
  output logic [AW-1:0] init_addr,
  output logic          init_we
);

  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_we   = 1'b0;
    case (state)
      INIT: begin
        init_we = 1'b1;
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  assign ready     = (state == RUN);
  assign init_addr = cnt;

endmodule

// File: rtl/ram_regfile_mp.sv
// ram_regfile_mp: DEPTH x WIDTH register file with one read/write port (A),
// one write-only port (B) and one read-only port (C). All state changes on
// the falling edge of clk.
//   clk  in  single clock, falling edge active
//   rst  in  asynchronous, active-high
//   bus  slave modport of ram_regfile_mp_if (ports A/B/C, ready, collision,
//        state)
// After reset the array is refilled with INIT_VALUE; port traffic is ignored
// until ready. On a same-address dual write port B wins and collision pulses
// for one cycle. Reads are write-first, including B-to-A/C forwarding.
module ram_regfile_mp
  import ram_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int INIT_VALUE = INIT_VALUE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_regfile_mp_if.slave      bus
);

  localparam int AW = $clog2(DEPTH);

  state_t           state;
  logic             ready;
  logic [AW-1:0]    init_addr;
  logic             init_we;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             run;
  logic             wr_a;
  logic             wr_b;
  logic             same_addr;
  logic [WIDTH-1:0] rd_next_a;
  logic [WIDTH-1:0] rd_next_c;

  logic [WIDTH-1:0] q_a;
  logic [WIDTH-1:0] q_c;
  logic             valid_a;
  logic             valid_c;
  logic             collision;

  ram_init_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .ready     (ready),
    .init_addr (init_addr),
    .init_we   (init_we)
  );

  assign run       = (state == RUN);
  assign wr_a      = run & bus.ce_a & bus.we_a;
  assign wr_b      = run & bus.ce_b & bus.we_b;
  assign same_addr = (bus.addr_a == bus.addr_b);

  // Write-first read data: port B has priority, then port A, then the array.
  always_comb begin
    rd_next_a = mem[bus.addr_a];
    if (wr_b && (bus.addr_b == bus.addr_a)) begin
      rd_next_a = bus.di_b;
    end else if (wr_a) begin
      rd_next_a = bus.di_a;
    end

    rd_next_c = mem[bus.addr_c];
    if (wr_b && (bus.addr_b == bus.addr_c)) begin
      rd_next_c = bus.di_b;
    end else if (wr_a && (bus.addr_a == bus.addr_c)) begin
      rd_next_c = bus.di_a;
    end
  end

  // The array itself is never reset; INIT rewrites it. Writes are blocked
  // while rst is high so an aborted cycle leaves nothing behind.
  always_ff @(negedge clk) begin
    if (!rst) begin
      if (init_we) begin
        mem[init_addr] <= WIDTH'(INIT_VALUE);
      end else begin
        if (wr_a && !(wr_b && same_addr)) begin
          mem[bus.addr_a] <= bus.di_a;
        end
        if (wr_b) begin
          mem[bus.addr_b] <= bus.di_b;
        end
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q_a       <= '0;
      q_c       <= '0;
      valid_a   <= 1'b0;
      valid_c   <= 1'b0;
      collision <= 1'b0;
    end else begin
      valid_a   <= run & bus.ce_a;
      valid_c   <= run & bus.ce_c;
      collision <= wr_a & wr_b & same_addr;
      if (run && bus.ce_a) begin
        q_a <= rd_next_a;
      end
      if (run && bus.ce_c) begin
        q_c <= rd_next_c;
      end
    end
  end

  assign bus.do_a      = valid_a ? q_a : 'z;
  assign bus.do_c      = valid_c ? q_c : 'z;
  assign bus.ready     = ready;
  assign bus.collision = collision;
  assign bus.state     = state;

endmodule
